// File: rtl/imem_scan_loader_if.sv
// Scan-pin and IMEM write-port bundle for imem_scan_loader.
// The loader drives the master side; pins and memory sit on the slave side.
interface imem_scan_loader_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LANES  = 1,
   parameter int unsigned ADDR_W = 10
);
   logic              scan_en;
   logic [LANES-1:0]  scan_in;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic [ADDR_W:0]   word_count;
   logic [DATA_W-1:0] checksum;
   logic              overflow;

   modport master (
      input  scan_en, scan_in,
      output mem_we, mem_addr, mem_wdata, cpu_hold, load_done,
             word_count, checksum, overflow
   );

   modport slave (
      output scan_en, scan_in,
      input  mem_we, mem_addr, mem_wdata, cpu_hold, load_done,
             word_count, checksum, overflow
   );
endinterface

// File: rtl/imem_scan_loader.sv
// Serial scan loader: deserialises LSB-first multi-lane scan data into words
// and writes them to consecutive IMEM addresses while holding the core.
module imem_scan_loader #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned LANES     = 1,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic               clk,
   input  logic               Rst_n,
   imem_scan_loader_if.master bus
);
   localparam int unsigned BEATS  = DATA_W / LANES;
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [ADDR_W:0]   CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

   if (DATA_W % LANES != 0) begin : g_lanes_chk
      $error("imem_scan_loader: DATA_W must be a multiple of LANES");
   end

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t            state, state_next;
   logic [BEAT_W-1:0] beat;
   logic [DATA_W-1:0] shift;
   logic [ADDR_W-1:0] next_addr;

   logic              start_c, hold_c, done_c, word_c;
   logic [DATA_W-1:0] word_data_c;
   logic [ADDR_W:0]   wc_base_c;
   logic [DATA_W-1:0] cs_base_c;
   logic [ADDR_W-1:0] addr_base_c;

   // Next-state decode; a load may start from IDLE or directly out of DONE
   always_comb begin
      state_next = state;
      start_c    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.scan_en) begin
               state_next = LOAD;
               start_c    = 1'b1;
            end
         end
         LOAD: begin
            if (!bus.scan_en) state_next = DONE;
         end
         DONE: begin
            if (bus.scan_en) begin
               state_next = LOAD;
               start_c    = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      hold_c = (state_next != IDLE);
      done_c = (state_next == DONE);
   end

   // Current beat merged into the shift image; start of a load rebases the counters
   always_comb begin
      word_data_c = shift;
      word_data_c[beat*LANES +: LANES] = bus.scan_in;
      word_c      = bus.scan_en && (beat == LAST_BEAT);
      wc_base_c   = start_c ? '0   : bus.word_count;
      cs_base_c   = start_c ? '0   : bus.checksum;
      addr_base_c = start_c ? BASE : next_addr;
   end

   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // mem_addr/mem_wdata double as the holding register so shifting never stalls
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         beat           <= '0;
         shift          <= '0;
         next_addr      <= BASE;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= BASE;
         bus.mem_wdata  <= '0;
         bus.cpu_hold   <= 1'b0;
         bus.load_done  <= 1'b0;
         bus.word_count <= '0;
         bus.checksum   <= '0;
         bus.overflow   <= 1'b0;
      end else begin
         bus.mem_we    <= 1'b0;
         bus.cpu_hold  <= hold_c;
         bus.load_done <= done_c;
         if (start_c) begin
            bus.word_count <= '0;
            bus.checksum   <= '0;
            bus.overflow   <= 1'b0;
            next_addr      <= BASE;
         end
         if (bus.scan_en) begin
            shift <= word_data_c;
            beat  <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
         end else begin
            beat  <= '0;
         end
         if (word_c) begin
            if (wc_base_c == CAPACITY) begin
               bus.overflow <= 1'b1;
            end else begin
               bus.mem_we     <= 1'b1;
               bus.mem_addr   <= addr_base_c;
               bus.mem_wdata  <= word_data_c;
               next_addr      <= addr_base_c + 1'b1;
               bus.word_count <= wc_base_c + 1'b1;
               bus.checksum   <= cs_base_c + word_data_c;
            end
         end
      end
   end
endmodule
